// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned PC_STEP_DEF = 4;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   // Occupancy counter width for the two-entry output queue (0..2).
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_q.sv
// Two-entry FIFO of tagged fetch packets; entry 0 is always the head.
module fetch_skid_q
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_pkt_t       push_pkt,
   input  logic             pop,
   output fetch_pkt_t       head_pkt,
   output logic [CNT_W-1:0] count
);

   fetch_pkt_t       ent_q [2];
   fetch_pkt_t       ent_d [2];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Shift-on-pop storage; flush wins over any same-cycle push.
   always_comb begin
      ent_d   = ent_q;
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == '0) ent_d[0] = push_pkt;
               else               ent_d[1] = push_pkt;
               count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
               ent_d[0] = ent_q[1];
               count_d  = count_q - CNT_W'(1);
            end
            2'b11: begin
               if (count_q == CNT_W'(1)) begin
                  ent_d[0] = push_pkt;
               end else begin
                  ent_d[0] = ent_q[1];
                  ent_d[1] = push_pkt;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   // The controller's issue rule must never let the queue overflow.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && push && !pop) begin
         assert (count_q != CNT_W'(2)) else $error("fetch_skid_q: push into full queue");
      end
   end

   assign head_pkt = ent_q[0];
   assign count    = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: issues instruction-memory reads, tags responses with
// their PC, queues them for decode and handles redirect, halt and reset.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
   parameter int unsigned     PC_STEP   = PC_STEP_DEF,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            mem_en,
   output logic [XLEN-1:0] mem_pc,
   input  logic [XLEN-1:0] mem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic            misalign_err,
   output logic            idle
);

   if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("fetch_ctrl: BUF_DEPTH must be 2");
   end

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  req_pc_q, req_pc_d;
   logic             infl_q, infl_d;
   logic             kill_q, kill_d;
   logic             misalign_q, misalign_d;

   logic             valid;
   logic             pop;
   logic             push;
   logic             issue;
   logic [2:0]       occ;
   logic [CNT_W-1:0] q_count;
   fetch_pkt_t       head_pkt;
   fetch_pkt_t       push_pkt;

   // Occupancy after this cycle's pop counts the in-flight read as a held slot.
   always_comb begin
      valid    = rst_n & (q_count != '0) & ~redirect_valid;
      pop      = valid & out_ready;
      push     = infl_q & ~kill_q;
      occ      = 3'(q_count) + 3'(infl_q) - 3'(pop);
      issue    = rst_n & ~halt & ~redirect_valid & (occ < 3'd2);
      push_pkt = '{pc: req_pc_q, instr: mem_instr};

      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      infl_d     = 1'b0;
      kill_d     = 1'b0;
      misalign_d = 1'b0;

      if (redirect_valid) begin
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         kill_d     = infl_q;
         misalign_d = |redirect_pc[1:0];
      end else if (issue) begin
         infl_d   = 1'b1;
         req_pc_d = pc_q;
         pc_d     = pc_q + XLEN'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         infl_q     <= 1'b0;
         kill_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         infl_q     <= infl_d;
         kill_q     <= kill_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_skid_q u_skid_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (push),
      .push_pkt (push_pkt),
      .pop      (pop),
      .head_pkt (head_pkt),
      .count    (q_count)
   );

   assign mem_en       = issue;
   assign mem_pc       = pc_q;
   assign out_valid    = valid;
   assign out_pc       = head_pkt.pc;
   assign out_instr    = head_pkt.instr;
   assign misalign_err = misalign_q;
   assign idle         = rst_n & halt & ~infl_q & (q_count == '0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenario tasks plus a randomized run checked
// against an occupancy-level reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n, mem_en, redirect_valid, halt, out_valid, out_ready;
   logic        misalign_err, idle;
   logic [31:0] mem_pc, mem_instr, redirect_pc, out_pc, out_instr;

   int n_vec = 0;
   int n_err = 0;

   fetch_ctrl #(.RESET_PC(RST_PC), .PC_STEP(4), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_en         (mem_en),
      .mem_pc         (mem_pc),
      .mem_instr      (mem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .misalign_err   (misalign_err),
      .idle           (idle)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      case (a)
         32'h0:   word_at = 32'h0000_0013;
         32'h4:   word_at = 32'h0010_0093;
         32'h8:   word_at = 32'h0020_0113;
         default: word_at = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // Synchronous instruction memory, one-cycle read latency.
   always @(posedge clk) if (mem_en === 1'b1) mem_instr <= word_at(mem_pc);

   // Reference model: counts of outstanding fetches and next expected PCs.
   logic [31:0] m_issue, m_head;
   int          m_out;
   bit          m_infl, m_mis, model_ok;

   initial begin
      bit e_valid, e_pop, e_en;
      model_ok = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            if (model_ok) begin
               n_vec++;
               if (mem_en !== 1'b0 || out_valid !== 1'b0 || idle !== 1'b0) begin
                  n_err++;
                  $display("FAIL sb_reset_outputs t=%0t got en=%b valid=%b idle=%b want 0 0 0",
                           $time, mem_en, out_valid, idle);
               end
            end
            m_issue = RST_PC; m_head = RST_PC; m_out = 0; m_infl = 0; m_mis = 0;
            model_ok = 1;
         end else if (model_ok) begin
            e_valid = ((m_out - int'(m_infl)) > 0) && !redirect_valid;
            e_pop   = e_valid && out_ready;
            e_en    = !halt && !redirect_valid && ((m_out - int'(e_pop)) < 2);
            n_vec++;
            if (mem_en !== e_en) begin
               n_err++; $display("FAIL sb_mem_en t=%0t got %b want %b", $time, mem_en, e_en);
            end
            n_vec++;
            if (mem_pc !== m_issue) begin
               n_err++; $display("FAIL sb_mem_pc t=%0t got %h want %h", $time, mem_pc, m_issue);
            end
            n_vec++;
            if (out_valid !== e_valid) begin
               n_err++; $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid, e_valid);
            end
            if (e_valid) begin
               n_vec++;
               if (out_pc !== m_head || out_instr !== word_at(m_head)) begin
                  n_err++;
                  $display("FAIL sb_out_data t=%0t got pc=%h instr=%h want pc=%h instr=%h",
                           $time, out_pc, out_instr, m_head, word_at(m_head));
               end
            end
            n_vec++;
            if (idle !== (halt && m_out == 0)) begin
               n_err++; $display("FAIL sb_idle t=%0t got %b want %b", $time, idle, (halt && m_out == 0));
            end
            n_vec++;
            if (misalign_err !== m_mis) begin
               n_err++; $display("FAIL sb_misalign t=%0t got %b want %b", $time, misalign_err, m_mis);
            end
            if (redirect_valid) begin
               m_issue = {redirect_pc[31:2], 2'b00};
               m_head  = m_issue;
               m_out   = 0;
               m_infl  = 0;
               m_mis   = (redirect_pc[1:0] != 2'b00);
            end else begin
               m_out  = m_out + int'(e_en) - int'(e_pop);
               m_infl = e_en;
               m_mis  = 0;
               if (e_en)  m_issue = m_issue + 32'd4;
               if (e_pop) m_head  = m_head + 32'd4;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; halt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         smp();
         n_vec++;
         if (mem_en !== 1'b0 || out_valid !== 1'b0 || idle !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold got en=%b valid=%b idle=%b want 0 0 0", mem_en, out_valid, idle);
         end
         cyc();
      end
      halt = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] w [3];
      w[0] = 32'h0000_0013; w[1] = 32'h0010_0093; w[2] = 32'h0020_0113;
      smp();
      n_vec++;
      if (mem_en !== 1'b1 || mem_pc !== RST_PC || out_valid !== 1'b0 || misalign_err !== 1'b0) begin
         n_err++;
         $display("FAIL stream_first_issue got en=%b pc=%h valid=%b mis=%b want 1 %h 0 0",
                  mem_en, mem_pc, out_valid, misalign_err, RST_PC);
      end
      cyc(); smp();
      n_vec++;
      if (out_valid !== 1'b0 || mem_en !== 1'b1 || mem_pc !== 32'h4) begin
         n_err++;
         $display("FAIL stream_cycle2 got valid=%b en=%b pc=%h want 0 1 00000004", out_valid, mem_en, mem_pc);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(); smp();
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== w[k]) begin
            n_err++;
            $display("FAIL stream_word%0d got valid=%b pc=%h instr=%h want 1 %h %h",
                     k, out_valid, out_pc, out_instr, 32'(4 * k), w[k]);
         end
      end
      for (int k = 0; k < 8; k++) begin
         cyc(); smp();
         n_vec++;
         if (out_valid !== 1'b1 || mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL stream_throughput got valid=%b en=%b want 1 1", out_valid, mem_en);
         end
      end
      cyc();
   endtask

   task automatic test_backpressure();
      int w; int got; logic [31:0] nxt;
      out_ready = 1'b0;
      do_reset();
      w = 0;
      smp();
      while (out_valid !== 1'b1 && w < 10) begin cyc(); smp(); w++; end
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_first_valid got %b want 1", out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) smp();
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== RST_PC || out_instr !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL bp_head_stable got valid=%b pc=%h instr=%h want 1 %h 00000013",
                     out_valid, out_pc, out_instr, RST_PC);
         end
         if (i == 4) begin
            n_vec++;
            if (mem_en !== 1'b0) begin
               n_err++; $display("FAIL bp_full_no_issue got en=%b want 0", mem_en);
            end
         end
         cyc();
      end
      out_ready = 1'b1;
      nxt = RST_PC; got = 0; w = 0;
      while (got < 6 && w < 30) begin
         smp();
         if (out_valid === 1'b1) begin
            n_vec++;
            if (out_pc !== nxt || out_instr !== word_at(nxt)) begin
               n_err++;
               $display("FAIL bp_order got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, nxt, word_at(nxt));
            end
            nxt = nxt + 32'd4;
            got++;
         end
         cyc();
         w++;
      end
      n_vec++;
      if (got != 6) begin
         n_err++; $display("FAIL bp_drain_count got %0d want 6", got);
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b1;
      do_reset();
      repeat (3) cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      smp();
      n_vec++;
      if (out_valid !== 1'b0 || mem_en !== 1'b0) begin
         n_err++; $display("FAIL redir_T got valid=%b en=%b want 0 0", out_valid, mem_en);
      end
      cyc();
      redirect_valid = 1'b0;
      smp();
      n_vec++;
      if (out_valid !== 1'b0 || mem_en !== 1'b1 || mem_pc !== 32'h100 || misalign_err !== 1'b0) begin
         n_err++;
         $display("FAIL redir_T1 got valid=%b en=%b pc=%h mis=%b want 0 1 00000100 0",
                  out_valid, mem_en, mem_pc, misalign_err);
      end
      cyc(); smp();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL redir_T2 got valid=%b want 0", out_valid);
      end
      cyc(); smp();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== word_at(32'h100)) begin
         n_err++;
         $display("FAIL redir_target got valid=%b pc=%h instr=%h want 1 00000100 %h",
                  out_valid, out_pc, out_instr, word_at(32'h100));
      end
      cyc();
   endtask

   task automatic test_misalign();
      int w;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      cyc();
      redirect_pc = 32'h0000_0102;
      smp();
      n_vec++;
      if (misalign_err !== 1'b0 || mem_en !== 1'b0) begin
         n_err++; $display("FAIL mis_aligned_first got mis=%b en=%b want 0 0", misalign_err, mem_en);
      end
      cyc();
      redirect_valid = 1'b0;
      smp();
      n_vec++;
      if (misalign_err !== 1'b1 || mem_en !== 1'b1 || mem_pc !== 32'h100) begin
         n_err++;
         $display("FAIL mis_pulse got mis=%b en=%b pc=%h want 1 1 00000100", misalign_err, mem_en, mem_pc);
      end
      cyc(); smp();
      n_vec++;
      if (misalign_err !== 1'b0) begin
         n_err++; $display("FAIL mis_one_cycle got %b want 0", misalign_err);
      end
      w = 0;
      while (out_valid !== 1'b1 && w < 10) begin cyc(); smp(); w++; end
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
         n_err++; $display("FAIL mis_last_wins got valid=%b pc=%h want 1 00000100", out_valid, out_pc);
      end
      cyc();
   endtask

   task automatic test_halt();
      logic [31:0] p;
      out_ready = 1'b1;
      do_reset();
      repeat (4) cyc();
      halt = 1'b1;
      smp();
      p = out_pc;
      n_vec++;
      if (out_valid !== 1'b1 || mem_en !== 1'b0 || p !== 32'h8) begin
         n_err++; $display("FAIL halt_entry got valid=%b en=%b pc=%h want 1 0 00000008", out_valid, mem_en, p);
      end
      cyc(); smp();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== p + 32'd4 || idle !== 1'b0) begin
         n_err++;
         $display("FAIL halt_drain got valid=%b pc=%h idle=%b want 1 %h 0", out_valid, out_pc, idle, p + 32'd4);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(); smp();
         n_vec++;
         if (out_valid !== 1'b0 || idle !== 1'b1 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL halt_idle got valid=%b idle=%b en=%b want 0 1 0", out_valid, idle, mem_en);
         end
      end
      cyc();
      halt = 1'b0;
      smp();
      n_vec++;
      if (idle !== 1'b0 || mem_en !== 1'b1 || mem_pc !== p + 32'd8) begin
         n_err++;
         $display("FAIL halt_resume got idle=%b en=%b pc=%h want 0 1 %h", idle, mem_en, mem_pc, p + 32'd8);
      end
      cyc();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [3];
      exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      cyc();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp();
         n_vec++;
         if (mem_en !== 1'b1 || mem_pc !== exp_a[k]) begin
            n_err++; $display("FAIL wrap_issue%0d got en=%b pc=%h want 1 %h", k, mem_en, mem_pc, exp_a[k]);
         end
         cyc();
      end
      repeat (4) cyc();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      repeat (3) cyc();
      rst_n = 1'b0;
      smp();
      n_vec++;
      if (mem_en !== 1'b0 || out_valid !== 1'b0 || idle !== 1'b0) begin
         n_err++; $display("FAIL rmid_during got en=%b valid=%b idle=%b want 0 0 0", mem_en, out_valid, idle);
      end
      cyc();
      rst_n = 1'b1;
      smp();
      n_vec++;
      if (out_valid !== 1'b0 || mem_en !== 1'b1 || mem_pc !== RST_PC) begin
         n_err++;
         $display("FAIL rmid_restart got valid=%b en=%b pc=%h want 0 1 %h", out_valid, mem_en, mem_pc, RST_PC);
      end
      cyc(); smp();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL rmid_empty got valid=%b want 0", out_valid);
      end
      cyc(); smp();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== RST_PC || out_instr !== 32'h0000_0013) begin
         n_err++;
         $display("FAIL rmid_first got valid=%b pc=%h instr=%h want 1 %h 00000013", out_valid, out_pc, out_instr, RST_PC);
      end
      cyc();
   endtask

   task automatic test_random();
      int pops;
      pops = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_n          = ($urandom_range(199) != 0);
         redirect_valid = ($urandom_range(99) < 6);
         redirect_pc    = $urandom() & 32'h0000_0FFF;
         if ($urandom_range(7) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
         if ($urandom_range(19) == 0) halt = ~halt;
         out_ready = ($urandom_range(99) < 70);
         smp();
         if (out_valid === 1'b1 && out_ready) pops++;
         cyc();
      end
      rst_n = 1'b1; redirect_valid = 1'b0; halt = 1'b0; out_ready = 1'b1;
      n_vec++;
      if (pops < 500) begin
         n_err++; $display("FAIL rand_progress got %0d deliveries want at least 500", pops);
      end
      repeat (4) cyc();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misalign();
      test_halt();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
